// File: rtl/xadc_pkg.sv
// Shared XADC/DRP constants and the sampler FSM state type.
package xadc_pkg;

  localparam int unsigned XADC_RES_W = 12;
  localparam int unsigned DRP_ADDR_W = 7;
  localparam int unsigned DRP_DATA_W = 16;

  localparam logic [DRP_ADDR_W-1:0] ADDR_TEMP   = 7'h00;
  localparam logic [DRP_ADDR_W-1:0] ADDR_VCCINT = 7'h01;
  localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX0  = 7'h10;
  localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX1  = 7'h11;
  localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX3  = 7'h13;
  localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX11 = 7'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/xadc_drp_sampler.sv
// Reads NUM_CH XADC channels over DRP per trigger and publishes a coherent frame.
// Optional DRP read timeout: define XADC_DRP_SAMPLER_TIMEOUT_EN.
module xadc_drp_sampler
  import xadc_pkg::*;
#(
  parameter int unsigned           NUM_CH   = 2,
  parameter logic [DRP_ADDR_W-1:0] CH_ADDR0 = ADDR_VAUX3,
  parameter logic [DRP_ADDR_W-1:0] CH_ADDR1 = ADDR_VAUX11,
  parameter logic [DRP_ADDR_W-1:0] CH_ADDR2 = ADDR_VAUX0,
  parameter logic [DRP_ADDR_W-1:0] CH_ADDR3 = ADDR_VAUX1,
  parameter int unsigned           TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trigger,
  output logic                         drp_den,
  output logic [DRP_ADDR_W-1:0]        drp_daddr,
  output logic                         drp_dwe,
  input  logic                         drp_drdy,
  input  logic [DRP_DATA_W-1:0]        drp_do,
  output logic [XADC_RES_W*NUM_CH-1:0] ch_data,
  output logic                         sample_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic                         timeout_err
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DRP_ADDR_W-1:0] ADDR_TBL [4] = '{CH_ADDR0, CH_ADDR1, CH_ADDR2, CH_ADDR3};

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [XADC_RES_W-1:0]         shadow_q [NUM_CH];
  logic [XADC_RES_W-1:0]         shadow_d [NUM_CH];
  logic [XADC_RES_W*NUM_CH-1:0]  ch_data_q, ch_data_d;
  logic                          sample_valid_q, sample_valid_d;
  logic                          busy_q, busy_d;
  logic [1:0]                    tbl_idx;
  logic                          last_ch;
  logic                          unused_bits;

`ifdef XADC_DRP_SAMPLER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wait_expired;

  assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign unused_bits  = ^drp_do[3:0];
`else
  assign timeout_err  = 1'b0;
  assign unused_bits  = ^{drp_do[3:0], TIMEOUT};
`endif

  assign tbl_idx = 2'(idx_q);
  assign last_ch = (idx_q == IDX_W'(NUM_CH - 1));

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    shadow_d       = shadow_q;
    ch_data_d      = ch_data_q;
    sample_valid_d = 1'b0;
`ifdef XADC_DRP_SAMPLER_TIMEOUT_EN
    timeout_err    = 1'b0;
    wait_cnt_d     = (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      // busy_q also covers the sample_valid cycle, so a trigger there is an overrun
      ST_IDLE: begin
        if (trigger && !busy_q) begin
          state_d = ST_REQ;
          idx_d   = '0;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (drp_drdy) begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (idx_q == IDX_W'(k)) shadow_d[k] = drp_do[DRP_DATA_W-1:4];
          end
          if (last_ch) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_REQ;
          end
        end
`ifdef XADC_DRP_SAMPLER_TIMEOUT_EN
        else if (wait_expired) begin
          timeout_err = 1'b1;
          state_d     = ST_IDLE;
        end
`endif
      end
      ST_DONE: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          ch_data_d[k*XADC_RES_W +: XADC_RES_W] = shadow_q[k];
        end
        sample_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      ch_data_q      <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
`ifdef XADC_DRP_SAMPLER_TIMEOUT_EN
      wait_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      ch_data_q      <= ch_data_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      shadow_q       <= shadow_d;
`ifdef XADC_DRP_SAMPLER_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
`endif
    end
  end

  assign drp_den      = (state_q == ST_REQ);
  assign drp_daddr    = drp_den ? ADDR_TBL[tbl_idx] : '0;
  assign drp_dwe      = 1'b0;
  assign ch_data      = ch_data_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign overrun      = trigger && busy_q;

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Directed bench for xadc_drp_sampler with a fixed-latency DRP responder.
module tb_xadc_drp_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_do;
  logic [23:0] ch_data;
  logic        sample_valid, busy, overrun, timeout_err;

  always #4 clk = ~clk;

  xadc_drp_sampler #(.NUM_CH(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .drp_den(drp_den), .drp_daddr(drp_daddr), .drp_dwe(drp_dwe),
    .drp_drdy(drp_drdy), .drp_do(drp_do),
    .ch_data(ch_data), .sample_valid(sample_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  // DRP responder: drdy dly cycles after den, data = addr << 8
  logic [15:0] den_pipe = '0;
  logic [6:0]  addr_pipe [16];
  logic        model_en = 1'b1;
  logic        spur = 1'b0;
  int          dly = 4;

  always @(posedge clk) begin
    den_pipe     <= {den_pipe[14:0], drp_den};
    addr_pipe[0] <= drp_daddr;
    for (int i = 1; i < 16; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign drp_drdy = (model_en & den_pipe[dly-1]) | spur;
  assign drp_do   = {1'b0, addr_pipe[dly-1], 8'h00};

  // Event log sampled on the falling edge
  int unsigned ncyc = 0, last_trig = 0;
  int unsigned sv_cnt = 0, sv_cyc = 0, ov_cnt = 0, ov_cyc = 0, to_cnt = 0, to_cyc = 0;
  int unsigned den_cnt = 0, rise_cnt = 0, fall_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  int unsigned den_cyc [$];
  logic [6:0]  den_addr [$];
  logic [23:0] sv_data = '0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    if (trigger) last_trig = ncyc;
    if (drp_den) begin den_cnt++; den_cyc.push_back(ncyc); den_addr.push_back(drp_daddr); end
    if (sample_valid) begin sv_cnt++; sv_cyc = ncyc; sv_data = ch_data; end
    if (overrun) begin ov_cnt++; ov_cyc = ncyc; end
    if (timeout_err) begin to_cnt++; to_cyc = ncyc; end
    if (busy && !prev_busy) begin rise_cnt++; rise_cyc = ncyc; end
    if (!busy && prev_busy) begin fall_cnt++; fall_cyc = ncyc; end
    prev_busy = busy;
    ncyc++;
  end

  int unsigned n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic wait_sv(input int unsigned base, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (sv_cnt > base) return;
      tick(1);
    end
    check("sv_wait_expired", sv_cnt, base + 1);
  endtask

  initial begin
    int unsigned t0, sv0, ov0, den0, r0, f0, to0;
    logic [23:0] prev;

    // Reset state
    tick(3);
    check("rst_den", drp_den, 0);
    check("rst_daddr", drp_daddr, 0);
    check("rst_dwe", drp_dwe, 0);
    check("rst_ch_data", ch_data, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_to", timeout_err, 0);
    rst = 1'b0;
    tick(2);

    // 1: single frame timing and data
    den_cyc.delete(); den_addr.delete();
    sv0 = sv_cnt;
    pulse_trig();
    t0 = last_trig;
    wait_sv(sv0, 40);
    tick(3);
    check("f1_den0_lat", den_cyc[0] - t0, 1);
    check("f1_den0_addr", den_addr[0], 7'h13);
    check("f1_den1_lat", den_cyc[1] - t0, 6);
    check("f1_den1_addr", den_addr[1], 7'h1B);
    check("f1_den_count", den_cyc.size(), 2);
    check("f1_sv_lat", sv_cyc - t0, 12);
    check("f1_ch0", sv_data[11:0], 12'h130);
    check("f1_ch1", sv_data[23:12], 12'h1B0);
    check("f1_busy_rise", rise_cyc - t0, 1);
    check("f1_busy_fall", fall_cyc - t0, 13);
    check("f1_hold", ch_data, 24'h1B0130);

    // 2: trigger while busy is dropped
    sv0 = sv_cnt; ov0 = ov_cnt; r0 = rise_cnt; f0 = fall_cnt;
    pulse_trig();
    t0 = last_trig;
    tick(2);
    pulse_trig();
    tick(40);
    check("f2_ovr_count", ov_cnt - ov0, 1);
    check("f2_ovr_cyc", ov_cyc - t0, 3);
    check("f2_sv_count", sv_cnt - sv0, 1);
    check("f2_busy_rises", rise_cnt - r0, 1);
    check("f2_busy_falls", fall_cnt - f0, 1);
    check("f2_sv_lat", sv_cyc - t0, 12);

    // 3: reset mid-frame, late drdy ignored, then a clean frame
    sv0 = sv_cnt;
    pulse_trig();
    tick(2);
    rst = 1'b1;
    tick(1);
    check("f3_rst_den", drp_den, 0);
    check("f3_rst_busy", busy, 0);
    check("f3_rst_ch_data", ch_data, 0);
    rst = 1'b0;
    den0 = den_cnt;
    tick(20);
    check("f3_late_drdy_den", den_cnt - den0, 0);
    check("f3_late_drdy_sv", sv_cnt - sv0, 0);
    pulse_trig();
    t0 = last_trig;
    wait_sv(sv0, 40);
    check("f3_new_sv_lat", sv_cyc - t0, 12);
    check("f3_new_data", sv_data, 24'h1B0130);
    tick(5);

`ifdef XADC_DRP_SAMPLER_TIMEOUT_EN
    // 4: DRP never answers
    model_en = 1'b0;
    prev = ch_data; sv0 = sv_cnt; to0 = to_cnt;
    pulse_trig();
    t0 = last_trig;
    tick(20);
    check("f4_to_count", to_cnt - to0, 1);
    check("f4_to_lat", to_cyc - t0, 9);
    check("f4_no_sv", sv_cnt - sv0, 0);
    check("f4_ch_hold", ch_data, prev);
    check("f4_busy", busy, 0);
    model_en = 1'b1;
    tick(20);

    // 5: drdy on the last allowed WAIT cycle wins
    dly = 8;
    sv0 = sv_cnt; to0 = to_cnt;
    pulse_trig();
    t0 = last_trig;
    wait_sv(sv0, 60);
    check("f5_no_to", to_cnt - to0, 0);
    check("f5_sv_lat", sv_cyc - t0, 20);
    check("f5_data", sv_data, 24'h1B0130);
    tick(20);
    dly = 4;
`endif

    // 6: spurious idle drdy, then 100 frames 750 cycles apart
    sv0 = sv_cnt; den0 = den_cnt;
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(5);
    check("f6_spur_sv", sv_cnt - sv0, 0);
    check("f6_spur_den", den_cnt - den0, 0);
    ov0 = ov_cnt;
    for (int f = 0; f < 100; f++) begin
      pulse_trig();
      tick(100);
      spur = 1'b1;
      tick(1);
      spur = 1'b0;
      tick(648);
      check("f6_frame_data", sv_data, 24'h1B0130);
    end
    check("f6_sv_count", sv_cnt - sv0, 100);
    check("f6_ovr_count", ov_cnt - ov0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
